// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// operand width, funct3 op codes and FSM state encoding.
package mdu_seq_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-divide step over a 2*XLEN-bit accumulator.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic                mode_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next,
    output logic                q_bit
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   part;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] rem;
    logic            ge;

    // NOTE: every combinational output gets a default first so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        part     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge       = (part >= {1'b0, operand});
        // When ge holds the true difference is below operand, so XLEN bits suffice.
        diff     = part[XLEN-1:0] - operand;
        rem      = ge ? diff : part[XLEN-1:0];
        q_bit    = mode_div & ge;
        acc_next = {sum, acc[XLEN-1:1]};
        if (mode_div) begin
            // Quotient bit is merged into bit 0 by the caller via q_bit.
            acc_next = {rem, acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, operand
// registers and the sign-fix/result mux around the shared mdu_step datapath.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = mdu_seq_pkg::XLEN,
    parameter int CNT_W = mdu_seq_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state, state_next;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_q, b_q, opnd;
    logic              a_neg, b_neg;
    logic [2*XLEN-1:0] acc, step_acc;
    logic              step_q;
    logic [CNT_W-1:0]  cnt;

    logic              sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_val;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    mdu_step #(.XLEN(XLEN)) u_step (
        .mode_div (is_div(f3)),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Operand signedness, magnitudes and divide special cases (used in PREP).
    always_comb begin
        sign_a   = (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
        sign_b   = sign_a && (f3 != F3_MULHSU);
        neg_a    = sign_a & a_q[XLEN-1];
        neg_b    = sign_b & b_q[XLEN-1];
        mag_a    = neg_a ? -a_q : a_q;
        mag_b    = neg_b ? -b_q : b_q;
        div_zero = is_div(f3) && (b_q == '0);
        div_ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) && (a_q == MIN_NEG) && (b_q == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = f3[1] ? a_q : '1;
        end else begin
            special_val = f3[1] ? '0 : MIN_NEG;
        end
    end

    // Sign correction and result selection (used in FIX).
    always_comb begin
        prod = (a_neg ^ b_neg) ? -acc : acc;
        quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        unique case (f3)
            F3_MUL:                     fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            fix_val = quo;
            default:                    fix_val = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = PREP;
            PREP: state_next = special ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
        busy = (state == PREP) || (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f3     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        f3  <= funct3;
                        a_q <= srca;
                        b_q <= srcb;
                    end
                end
                PREP: begin
                    a_neg <= neg_a;
                    b_neg <= neg_b;
                    cnt   <= '0;
                    acc   <= {{XLEN{1'b0}}, (is_div(f3) ? mag_a : mag_b)};
                    opnd  <= is_div(f3) ? mag_b : mag_a;
                    if (special && !flush) result <= special_val;
                end
                CALC: begin
                    acc <= {step_acc[2*XLEN-1:1], step_acc[0] | step_q};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!flush) result <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a table of RV32M operations with hand-computed
// results and latencies, plus flush, reset and start-in-DONE sequences.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    mdu_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .srca    (srca),
        .srcb    (srcb),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h, want %h", name, id, act, exp);
        end
    endtask

    // Issues one op, scrambles the operand inputs after the accepting edge and
    // returns at the negedge of the cycle in which done was seen.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int id);
        int seen;
        seen = 0;
        @(negedge clk);
        funct3 = f3;
        srca   = a;
        srcb   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        srca   = $urandom;
        srcb   = $urandom;
        funct3 = 3'($urandom);
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_c1", id, {31'b0, busy}, 32'd1);
            if (done) seen = c;
        end
        check("done_cycle", id, seen, lat);
        check("result", id, result, exp);
        check("busy_in_done", id, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
        vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35};
        vecs[6]  = '{F3_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 35};
        vecs[7]  = '{F3_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 35};
        vecs[8]  = '{F3_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2};
        vecs[9]  = '{F3_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2};
        vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[12] = '{F3_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 35};
        vecs[13] = '{F3_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 35};
        vecs[14] = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
        vecs[15] = '{F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35};
        vecs[16] = '{F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
        vecs[17] = '{F3_MUL,    32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 35};
        vecs[18] = '{F3_REMU,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 2};

        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = '0;
        srca    = '0;
        srcb    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   0, {31'b0, busy}, 32'd0);
        check("rst_done",   0, {31'b0, done}, 32'd0);
        check("rst_result", 0, result, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);
        end

        // Flush during cycle 10 of a MUL: abort with no done, result kept.
        @(negedge clk);
        funct3 = F3_MUL;
        srca   = 32'd7;
        srcb   = 32'hFFFF_FFFD;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy",   100, {31'b0, busy}, 32'd0);
        check("flush_done",   100, {31'b0, done}, 32'd0);
        check("flush_result", 100, result, vecs[NVEC-1].exp);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("flush_no_done", 100, seen, 0);
        run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 35, 101);

        // Flush and start together in IDLE: request dropped.
        @(negedge clk);
        funct3 = F3_MUL;
        srca   = 32'd3;
        srcb   = 32'd3;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        seen  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy || done) seen = 1;
        end
        check("flush_start_idle", 102, seen, 0);
        check("flush_start_result", 102, result, 32'd14);

        // Start held during DONE is ignored.
        run_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 103);
        funct3 = F3_MUL;
        srca   = 32'd2;
        srcb   = 32'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy || done) seen = 1;
        end
        check("start_in_done_ignored", 103, seen, 0);
        check("start_in_done_result", 103, result, 32'hFFFF_FFFF);

        // Asynchronous reset mid-CALC clears outputs at once.
        @(negedge clk);
        funct3 = F3_MUL;
        srca   = 32'd9;
        srcb   = 32'd9;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 104, {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",   104, {31'b0, busy}, 32'd0);
        check("mid_rst_done",   104, {31'b0, done}, 32'd0);
        check("mid_rst_result", 104, result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("rst_no_done", 104, seen, 0);
        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 105);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
